uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmit path between NUM_REQ byte-stream requesters.
- Presents a single valid/ready byte stream to the UART transmitter, which drains one byte per frame.
- Grant is held for a whole multi-byte packet (delimited by req_last) so packets from different requesters never interleave on the line.
- A watchdog releases a stalled grant.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit blocks:
//                arbiter state encoding, grant-index width helper and the
//                parity-mode codes used by the UART framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Arbiter FSM: waiting to arbitrate, or holding a grant
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Index width for a vector of n requesters (never narrower than one bit)
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Parity-mode codes shared with the UART framer
   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin priority picker. Returns the first
//                set request bit found when searching from rr_ptr upward with
//                wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first hit wins
   always_comb begin : p_pick
      logic [IDX_W-1:0] w_cand;
      w_cand = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[w_cand]) begin
            found = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmit byte stream
//                between NUM_REQ requesters. The grant is held for a whole
//                packet (up to req_last) and a watchdog revokes a grant whose
//                requester goes silent mid-packet.
//  Config      : UART_TX_ARB_PKT_LOCK_EN - when defined, the grant persists
//                until an accepted req_last beat; when undefined every beat
//                is treated as last (byte-level round-robin).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_valid,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_ready,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int c_gnt_w = idx_width(NUM_REQ);
   localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

`ifdef UART_TX_ARB_PKT_LOCK_EN
   localparam bit c_pkt_lock = 1'b1;
`else
   localparam bit c_pkt_lock = 1'b0;
`endif

   arb_state_t                state_q,     state_d;
   logic [c_gnt_w-1:0]        grant_q,     grant_d;
   logic [c_gnt_w-1:0]        rr_ptr_q,    rr_ptr_d;
   logic [c_cnt_w-1:0]        wd_cnt_q,    wd_cnt_d;
   logic                      tx_valid_q,  tx_valid_d;
   logic [DATA_WIDTH-1:0]     tx_data_q,   tx_data_d;
   logic                      timeout_q,   timeout_d;

   logic                      w_pick_found;
   logic [c_gnt_w-1:0]        w_pick_idx;
   logic                      w_slot_free;
   logic                      w_accept;
   logic                      w_is_last;
   logic [c_gnt_w-1:0]        w_grant_next;
   logic [c_cnt_w-1:0]        w_wd_inc;
   logic [DATA_WIDTH-1:0]     w_slice;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_gnt_w)
   ) u_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .found   (w_pick_found),
      .idx     (w_pick_idx)
   );

   // Next-state, handshake and output-register load logic
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      wd_cnt_d   = wd_cnt_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      timeout_d  = 1'b0;
      req_ready  = '0;

      // Output slot can take a byte if empty or being drained this cycle
      w_slot_free  = !tx_valid_q || tx_ready;
      w_slice      = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      w_accept     = (state_q == LOCKED) && req_valid[grant_q] && w_slot_free;
      w_is_last    = c_pkt_lock ? req_last[grant_q] : 1'b1;
      w_grant_next = (grant_q == c_gnt_w'(NUM_REQ - 1)) ? '0 : grant_q + c_gnt_w'(1);
      w_wd_inc     = wd_cnt_q + c_cnt_w'(1);

      if (state_q == LOCKED) begin
         req_ready[grant_q] = w_slot_free;
      end

      // A new beat reloads the register; a drain with no beat empties it
      if (w_accept) begin
         tx_valid_d = 1'b1;
         tx_data_d  = w_slice;
      end else if (tx_ready) begin
         tx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (w_pick_found) begin
               grant_d  = w_pick_idx;
               state_d  = LOCKED;
               wd_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (w_accept) begin
               // An accept always beats a coincident watchdog expiry
               wd_cnt_d = '0;
               if (w_is_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = w_grant_next;
               end
            end else if ((TIMEOUT_CYCLES > 0) && !req_valid[grant_q]) begin
               // Only silent cycles count; backpressured cycles do not
               if (w_wd_inc == c_timeout) begin
                  state_d   = IDLE;
                  rr_ptr_d  = w_grant_next;
                  wd_cnt_d  = '0;
                  timeout_d = 1'b1;
               end else begin
                  wd_cnt_d = w_wd_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         wd_cnt_q   <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         wd_cnt_q   <= wd_cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         timeout_q  <= timeout_d;
      end
   end

   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q == LOCKED);
   assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter
//                (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=8). Expectations
//                follow the build option UART_TX_ARB_PKT_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 8;
`ifdef UART_TX_ARB_PKT_LOCK_EN
   localparam bit PKT_LOCK = 1'b1;
`else
   localparam bit PKT_LOCK = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic [1:0]    grant_id;
   logic          busy;
   logic          timeout_err;

   uart_tx_arbiter #(
      .NUM_REQ        (NR),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Per-requester packet queues and observation logs
   logic [7:0] qd [NR][$];
   bit         ql [NR][$];
   logic [7:0] out_q [$];
   int         out_cyc [$];
   int         acc_q [$];
   int         onehot_bad, hold_bad, ready_bad, stall_valid;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pkt(input int r, input logic [7:0] d, input bit l);
      qd[r].push_back(d);
      ql[r].push_back(l);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         qd[i].delete();
         ql[i].delete();
      end
      out_q.delete();
      out_cyc.delete();
      acc_q.delete();
      onehot_bad = 0; hold_bad = 0; ready_bad = 0; stall_valid = 0;
      cyc();
      rst = 1'b0;
   endtask

   // Requesters present queue heads; tx_ready is low during [stall_from, stall_to)
   task automatic run(input int ncyc, input int stall_from, input int stall_to);
      logic [7:0]    pdata;
      logic          pvalid;
      logic          pready;
      logic [NR-1:0] acc;
      pdata = '0; pvalid = 1'b0; pready = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < NR; i++) begin
            req_valid[i]         = (qd[i].size() > 0);
            req_data[i*DW +: DW] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
            req_last[i]          = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
         end
         tx_ready = !(c >= stall_from && c < stall_to);
         #1;
         if (!$onehot0(req_ready)) onehot_bad++;
         if (pvalid && !pready && (!tx_valid || tx_data !== pdata)) hold_bad++;
         if (tx_valid && !tx_ready && req_ready !== '0) ready_bad++;
         if (tx_valid && !tx_ready) stall_valid++;
         if (tx_valid && tx_ready) begin
            out_q.push_back(tx_data);
            out_cyc.push_back(c);
         end
         acc = req_valid & req_ready;
         for (int i = 0; i < NR; i++) if (acc[i]) acc_q.push_back(i);
         pvalid = tx_valid; pdata = tx_data; pready = tx_ready;
         cyc();
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               void'(qd[i].pop_front());
               void'(ql[i].pop_front());
            end
         end
      end
      req_valid = '0;
      tx_ready  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
      cyc(); cyc();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      rst = 1'b0;
   endtask

   task automatic test_rr_all();
      int         exp_a [$] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d [$] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      do_reset();
      push_pkt(0, 8'h10, 1'b1); push_pkt(1, 8'h11, 1'b1);
      push_pkt(2, 8'h12, 1'b1); push_pkt(3, 8'h13, 1'b1);
      push_pkt(0, 8'h14, 1'b1);
      run(14, 0, 0);
      checks++; if (acc_q.size() !== 5) begin errors++; $display("FAIL rr_all_grants: got %0d grants expected 5", acc_q.size()); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (acc_q[i] !== exp_a[i]) begin errors++; $display("FAIL rr_all_order[%0d]: got %0d expected %0d", i, acc_q[i], exp_a[i]); end
      end
      checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL rr_all_bytes: got %0d bytes expected 5", out_q.size()); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (out_q[i] !== exp_d[i]) begin errors++; $display("FAIL rr_all_data[%0d]: got %h expected %h", i, out_q[i], exp_d[i]); end
      end
      checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL rr_all_onehot: got %0d bad cycles expected 0", onehot_bad); end
   endtask

   task automatic test_single_packet();
      logic [7:0] exp_d [$] = '{8'hA1, 8'hA2, 8'hA3};
      int gap;
      gap = PKT_LOCK ? 1 : 2;
      do_reset();
      push_pkt(1, 8'hA1, 1'b0); push_pkt(1, 8'hA2, 1'b0); push_pkt(1, 8'hA3, 1'b1);
      run(10, 0, 0);
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL pkt_grant_id: got %0d expected 1", grant_id); end
      checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL pkt_bytes: got %0d bytes expected 3", out_q.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (out_q[i] !== exp_d[i]) begin errors++; $display("FAIL pkt_data[%0d]: got %h expected %h", i, out_q[i], exp_d[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            checks++; if (out_cyc[i] - out_cyc[i-1] !== gap) begin errors++; $display("FAIL pkt_spacing[%0d]: got %0d expected %0d", i, out_cyc[i] - out_cyc[i-1], gap); end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pkt_busy_after: got %b expected 0", busy); end
      // Round-robin pointer now sits at 2: with 0, 2 and 3 requesting, 2 wins
      acc_q.delete();
      push_pkt(0, 8'h01, 1'b1); push_pkt(2, 8'h02, 1'b1); push_pkt(3, 8'h03, 1'b1);
      run(2, 0, 0);
      checks++; if (acc_q.size() !== 1 || acc_q[0] !== 2) begin errors++; $display("FAIL pkt_rr_ptr: got first grantee %0d expected 2", (acc_q.size() > 0) ? acc_q[0] : -1); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [$];
      if (PKT_LOCK) exp_d = '{8'h20, 8'h21, 8'h22, 8'h30};
      else          exp_d = '{8'h20, 8'h30, 8'h21, 8'h22};
      do_reset();
      push_pkt(0, 8'h20, 1'b0); push_pkt(0, 8'h21, 1'b0); push_pkt(0, 8'h22, 1'b1);
      push_pkt(2, 8'h30, 1'b1);
      run(18, 3, 8);
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
      checks++; if (ready_bad !== 0) begin errors++; $display("FAIL bp_ready: got %0d cycles with req_ready expected 0", ready_bad); end
      checks++; if (stall_valid !== (PKT_LOCK ? 5 : 4)) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected %0d", stall_valid, PKT_LOCK ? 5 : 4); end
      checks++; if (out_q.size() !== 4) begin errors++; $display("FAIL bp_bytes: got %0d bytes expected 4", out_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (out_q[i] !== exp_d[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, out_q[i], exp_d[i]); end
      end
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      tx_ready = 1'b0;
      req_data[31:24] = 8'h40;
      req_last  = '0;
      req_valid = 4'b1000;
      cyc();
      checks++; if (busy !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL to_grant: got busy=%b id=%0d expected busy=1 id=3", busy, grant_id); end
      if (PKT_LOCK) cyc();
      req_valid = '0;
      bad = 0;
      for (int i = 0; i < TO; i++) begin
         #1;
         if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
         cyc();
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL to_early: got %0d early cycles expected 0", bad); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
      if (PKT_LOCK) begin
         checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h40) begin errors++; $display("FAIL to_pending: got v=%b d=%h expected v=1 d=40", tx_valid, tx_data); end
      end
      tx_ready = 1'b1;
      cyc();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", timeout_err); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL to_drain: got %b expected 0", tx_valid); end
      req_data[7:0] = 8'h41;
      req_valid = 4'b1001;
      cyc();
      checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL to_rr_ptr: got id=%0d busy=%b expected id=0 busy=1", grant_id, busy); end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      bit reached;
      do_reset();
      tx_ready = 1'b0;
      req_data[15:8] = 8'hB1;
      req_last  = '0;
      req_valid = 4'b0010;
      reached = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!reached) begin
            cyc();
            if (busy && tx_valid) reached = 1'b1;
         end
      end
      checks++; if (!reached) begin errors++; $display("FAIL rstmid_setup: got busy=%b tx_valid=%b expected 1/1", busy, tx_valid); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx: got v=%b d=%h expected v=0 d=00", tx_valid, tx_data); end
      checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_grant: got busy=%b id=%0d expected 0/0", busy, grant_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_byte_interleave();
      logic [7:0] exp_d [$];
      if (PKT_LOCK) exp_d = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62};
      else          exp_d = '{8'h50, 8'h60, 8'h51, 8'h61, 8'h52, 8'h62};
      do_reset();
      push_pkt(0, 8'h50, 1'b0); push_pkt(0, 8'h51, 1'b0); push_pkt(0, 8'h52, 1'b0);
      push_pkt(1, 8'h60, 1'b0); push_pkt(1, 8'h61, 1'b0); push_pkt(1, 8'h62, 1'b0);
      run(40, 0, 0);
      checks++; if (out_q.size() !== 6) begin errors++; $display("FAIL ilv_bytes: got %0d bytes expected 6", out_q.size()); end
      else for (int i = 0; i < 6; i++) begin
         checks++; if (out_q[i] !== exp_d[i]) begin errors++; $display("FAIL ilv_order[%0d]: got %h expected %h", i, out_q[i], exp_d[i]); end
      end
      checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL ilv_onehot: got %0d bad cycles expected 0", onehot_bad); end
   endtask

   initial begin
      test_reset();
      test_rr_all();
      test_single_packet();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_byte_interleave();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation still running at %0t", $time);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
